// File: rtl/deserializer16_if.sv
// Bus bundle for deserializer16: serial input beats, the held output word with
// its valid/ready handshake, status flags and a debug view of the FSM state.
interface deserializer16_if;
    // Handshake: a sin beat is taken on every clk edge where sin_valid=1 (there is
    // no back-pressure on sin). The word on out moves to the consumer on an edge
    // where out_valid=1 and out_ready=1. While out_valid=1, out is held stable.
    // out_ready is ignored while out_valid=0.
    logic        sin;
    logic        sin_valid;
    logic        sin_start;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bitcnt;
    logic        overrun;
    logic        perr;
    logic [1:0]  dbg_state;

    modport master (
        output sin, sin_valid, sin_start, out_ready,
        input  out, out_valid, bitcnt, overrun, perr, dbg_state
    );

    modport slave (
        input  sin, sin_valid, sin_start, out_ready,
        output out, out_valid, bitcnt, overrun, perr, dbg_state
    );
endinterface

// File: rtl/deserializer16.sv
// 16-bit LSB-first deserializer with a one-word holding register and sticky overrun.
// Define DESER_PARITY_EN to append an even-parity beat after each 16-bit frame.
module deserializer16 (
    input  logic              clk,
    input  logic              rst,
    deserializer16_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1
`ifdef DESER_PARITY_EN
        , ST_PARITY = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        overrun_q, overrun_d;
    logic        wr_en;
    logic [3:0]  wr_pos;
    logic [15:0] wr_sel;
    logic        restart;
    logic        present;
`ifdef DESER_PARITY_EN
    logic        perr_q, perr_d;
    logic        perr_set;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        wr_en    = 1'b0;
        wr_pos   = 4'd0;
        wr_sel   = 16'd0;
        restart  = 1'b0;
        present  = 1'b0;
`ifdef DESER_PARITY_EN
        perr_set = 1'b0;
`endif
        if (bus.sin_valid) begin
            if (bus.sin_start) begin
                restart = 1'b1;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        wr_en    = 1'b1;
                        wr_pos   = bitcnt_q;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd15) begin
`ifdef DESER_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_IDLE;
                            present = 1'b1;
`endif
                        end
                    end
`ifdef DESER_PARITY_EN
                    ST_PARITY: begin
                        state_d = ST_IDLE;
                        if (bus.sin == ^shift_q) begin
                            present = 1'b1;
                        end else begin
                            perr_set = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        // A start beat abandons any partial word, including one awaiting parity.
        if (restart) begin
            shift_d  = 16'd0;
            wr_en    = 1'b1;
            wr_pos   = 4'd0;
            bitcnt_d = 4'd1;
            state_d  = ST_COLLECT;
        end

        if (wr_en) begin
            wr_sel = 16'd1 << wr_pos;
        end
        for (int i = 0; i < 16; i++) begin
            if (wr_sel[i]) begin
                shift_d[i] = bus.sin;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (present) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = shift_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef DESER_PARITY_EN
    always_comb begin
        perr_d = perr_q | perr_set;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= 16'd0;
            bitcnt_q    <= 4'd0;
            out_q       <= 16'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bitcnt    = bitcnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;

endmodule
